// File: rtl/spi_pixel_framer.sv
// rtl/spi_pixel_framer.sv - SPI byte stream to double-buffered per-channel LED pixel RAM framer
module spi_pixel_framer #(
  parameter int NUM_LEDS      = 256,
  parameter int NUM_CHAN      = 4,
  parameter int BYTES_PER_LED = 3,
  localparam int ADDR_W = $clog2(NUM_LEDS),
  localparam int CH_W   = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1,
  localparam int CNT_W  = ADDR_W + 1
) (
  input  logic                         CLOCK_50,
  input  logic                         RESET_N,
  input  logic                         ssel,
  input  logic [7:0]                   spi_data,
  input  logic                         spi_ready,
  output logic                         wr_en,
  output logic [CH_W+1+ADDR_W-1:0]     wr_addr,
  output logic [31:0]                  wr_data,
  input  logic [NUM_CHAN-1:0]          ws_reset_state,
  output logic [NUM_CHAN-1:0]          ws_bank,
  output logic [NUM_CHAN*CNT_W-1:0]    ws_count,
  output logic                         frame_done,
  output logic                         frame_err
);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA, S_DRAIN} state_t;

  state_t                  r_state;
  logic                    r_ssel_meta;
  logic                    r_ssel_sync;
  logic                    r_ssel_d;
  logic [1:0]              r_warm;
  logic                    r_armed;
  logic [CH_W-1:0]         r_ch;
  logic                    r_wbank;
  logic [CNT_W-1:0]        r_led_idx;
  logic [1:0]              r_byte_cnt;
  logic [23:0]             r_shift;
  logic                    r_wr_en;
  logic [CH_W+1+ADDR_W-1:0] r_wr_addr;
  logic [31:0]             r_wr_data;
  logic                    r_frame_done;
  logic                    r_frame_err;
  logic [NUM_CHAN-1:0]     r_disp_bank;
  logic [NUM_CHAN-1:0]     r_pending;
  logic [CNT_W-1:0]        r_count [NUM_CHAN][2];
  logic [CNT_W-1:0]        r_ws_count [NUM_CHAN];

  logic                    w_start;
  logic                    w_end;
  logic [NUM_CHAN-1:0]     w_swap;
  logic [NUM_CHAN-1:0]     w_disp_next;
  logic                    w_hdr_ok;
  logic [CH_W-1:0]         w_hdr_ch;
  logic [31:0]             w_packed;
  logic                    w_last_byte;
  logic                    w_idx_full;
  logic                    w_hdr_accept;
  logic                    w_led_write;
  logic                    w_commit;

  // Frame start is only honoured once a genuine high level of ssel has been
  // seen after reset, so a select held low across reset never opens a frame.
  assign w_start     = r_armed & r_ssel_d & ~r_ssel_sync;
  assign w_end       = r_ssel_sync & ~r_ssel_d;
  assign w_swap      = r_pending & ws_reset_state;
  assign w_disp_next = r_disp_bank ^ w_swap;
  assign w_hdr_ok    = ({24'd0, spi_data} < 32'(NUM_CHAN));
  assign w_hdr_ch    = spi_data[CH_W-1:0];
  assign w_packed    = {r_shift, spi_data};
  assign w_last_byte = (r_byte_cnt == 2'(BYTES_PER_LED - 1));
  assign w_idx_full  = (r_led_idx == CNT_W'(NUM_LEDS));
  assign w_hdr_accept = (r_state == S_HEADER) & ~w_end & spi_ready & w_hdr_ok;
  assign w_led_write  = (r_state == S_DATA) & ~w_end & spi_ready & ~w_idx_full & w_last_byte;
  assign w_commit     = (r_state == S_DATA) & w_end;

  // Two-flop ssel synchronizer, edge history and post-reset arming.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_ssel_meta <= 1'b1;
      r_ssel_sync <= 1'b1;
      r_ssel_d    <= 1'b1;
      r_warm      <= 2'b00;
      r_armed     <= 1'b0;
    end else begin
      r_ssel_meta <= ssel;
      r_ssel_sync <= r_ssel_meta;
      r_ssel_d    <= r_ssel_sync;
      r_warm      <= {r_warm[0], 1'b1};
      if (r_warm[1] && r_ssel_sync) begin
        r_armed <= 1'b1;
      end
    end
  end

  // Frame FSM: header decode, byte packing and registered write/status outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_state      <= S_IDLE;
      r_ch         <= '0;
      r_wbank      <= 1'b0;
      r_led_idx    <= '0;
      r_byte_cnt   <= '0;
      r_shift      <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state    <= S_HEADER;
            r_led_idx  <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
          end
        end
        S_HEADER: begin
          if (w_end) begin
            r_state <= S_IDLE;
          end else if (spi_ready) begin
            if (w_hdr_ok) begin
              r_ch    <= w_hdr_ch;
              r_wbank <= ~w_disp_next[w_hdr_ch];
              r_state <= S_DATA;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_DRAIN;
            end
          end
        end
        S_DATA: begin
          if (w_end) begin
            r_frame_done <= 1'b1;
            r_state      <= S_IDLE;
          end else if (spi_ready) begin
            if (w_idx_full) begin
              r_frame_err <= 1'b1;
            end else if (w_last_byte) begin
              r_wr_en    <= 1'b1;
              r_wr_addr  <= {r_ch, r_wbank, r_led_idx[ADDR_W-1:0]};
              r_wr_data  <= w_packed;
              r_led_idx  <= r_led_idx + 1'b1;
              r_byte_cnt <= '0;
              r_shift    <= '0;
            end else begin
              r_shift    <= w_packed[23:0];
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_end) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Per-channel bank swap, pending flag and per-bank LED counts.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_disp_bank <= '0;
      r_pending   <= '0;
      for (int c = 0; c < NUM_CHAN; c++) begin
        r_count[c][0] <= '0;
        r_count[c][1] <= '0;
        r_ws_count[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHAN; c++) begin
        if (w_swap[c]) begin
          r_disp_bank[c] <= ~r_disp_bank[c];
          r_pending[c]   <= 1'b0;
          r_ws_count[c]  <= r_count[c][~r_disp_bank[c]];
        end
        if (w_hdr_accept && (w_hdr_ch == CH_W'(c))) begin
          r_pending[c] <= 1'b0;
          r_count[c][~w_disp_next[c]] <= '0;
        end
        if (w_led_write && (r_ch == CH_W'(c)) &&
            (r_count[c][r_wbank] != CNT_W'(NUM_LEDS))) begin
          r_count[c][r_wbank] <= r_count[c][r_wbank] + 1'b1;
        end
        if (w_commit && (r_ch == CH_W'(c))) begin
          r_pending[c] <= 1'b1;
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CHAN; g++) begin : g_cnt
      assign ws_count[g*CNT_W +: CNT_W] = r_ws_count[g];
    end
  endgenerate

  assign ws_bank    = r_disp_bank;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_spi_pixel_framer.sv
// tb/tb_spi_pixel_framer.sv - randomized self-checking bench for spi_pixel_framer
module tb_spi_pixel_framer;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N;
  logic        ssel;
  logic [7:0]  spi_data;
  logic        spi_ready;
  logic [3:0]  ws_rst;

  logic        wr_en_a, wr_en_b;
  logic [4:0]  wr_addr_a;
  logic [5:0]  wr_addr_b;
  logic [31:0] wr_data_a, wr_data_b;
  logic [3:0]  ws_bank_a, ws_bank_b;
  logic [11:0] ws_count_a;
  logic [15:0] ws_count_b;
  logic        frame_done_a, frame_done_b;
  logic        frame_err_a, frame_err_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  spi_pixel_framer #(.NUM_LEDS(4), .NUM_CHAN(4), .BYTES_PER_LED(3)) dut_a (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .ssel(ssel), .spi_data(spi_data),
    .spi_ready(spi_ready), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .ws_reset_state(ws_rst), .ws_bank(ws_bank_a), .ws_count(ws_count_a),
    .frame_done(frame_done_a), .frame_err(frame_err_a));

  spi_pixel_framer #(.NUM_LEDS(8), .NUM_CHAN(4), .BYTES_PER_LED(4)) dut_b (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .ssel(ssel), .spi_data(spi_data),
    .spi_ready(spi_ready), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .ws_reset_state(ws_rst), .ws_bank(ws_bank_b), .ws_count(ws_count_b),
    .frame_done(frame_done_b), .frame_err(frame_err_b));

  // Reference model state, index 0 = dut_a, 1 = dut_b
  int m_disp [2][4];
  int m_pend [2][4];
  int m_cnt  [2][4][2];
  int m_wsc  [2][4];
  int m_err  [2];
  int m_done [2];
  logic [63:0] exp0[$], exp1[$], got0[$], got1[$];
  int done_a = 0, done_b = 0;
  logic [7:0] pay [64];

  // Observe DUT outputs on the falling edge
  always @(negedge CLOCK_50) begin
    if (wr_en_a) got0.push_back((64'(wr_addr_a) << 32) | 64'(wr_data_a));
    if (wr_en_b) got1.push_back((64'(wr_addr_b) << 32) | 64'(wr_data_b));
    if (frame_done_a) done_a++;
    if (frame_done_b) done_b++;
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_err[d] = 0;
      for (int c = 0; c < 4; c++) begin
        m_disp[d][c] = 0; m_pend[d][c] = 0; m_wsc[d][c] = 0;
        m_cnt[d][c][0] = 0; m_cnt[d][c][1] = 0;
      end
    end
    exp0.delete(); exp1.delete();
  endtask

  task automatic model_swap(input logic [3:0] bits);
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++)
        if (m_pend[d][c] != 0 && bits[c]) begin
          m_disp[d][c] = 1 - m_disp[d][c];
          m_pend[d][c] = 0;
          m_wsc[d][c]  = m_cnt[d][c][m_disp[d][c]];
        end
  endtask

  task automatic model_frame(input bit hp, input int hdr, input int plen);
    int nl, bpl, aw, ch, wb, n;
    logic [63:0] addr, data;
    if (!hp) return;
    for (int d = 0; d < 2; d++) begin
      nl  = (d == 0) ? 4 : 8;
      bpl = (d == 0) ? 3 : 4;
      aw  = (d == 0) ? 2 : 3;
      if (hdr >= 4) begin
        m_err[d] = 1;
        continue;
      end
      ch = hdr;
      wb = 1 - m_disp[d][ch];
      m_pend[d][ch] = 0;
      n = plen / bpl;
      if (plen > nl * bpl) m_err[d] = 1;
      if (n > nl) n = nl;
      for (int i = 0; i < n; i++) begin
        data = 0;
        for (int k = 0; k < bpl; k++) data = (data << 8) | 64'(pay[i*bpl+k]);
        addr = 64'((ch << (aw + 1)) | (wb << aw) | i);
        if (d == 0) exp0.push_back((addr << 32) | data);
        else        exp1.push_back((addr << 32) | data);
      end
      m_cnt[d][ch][wb] = n;
      m_pend[d][ch] = 1;
      m_done[d]++;
    end
    model_swap(ws_rst);
  endtask

  task automatic send_byte(input logic [7:0] b);
    spi_data  = b;
    spi_ready = 1'b1;
    tick();
    spi_ready = 1'b0;
    spi_data  = 8'($urandom);
    repeat ($urandom % 3) tick();
  endtask

  task automatic send_frame(input bit hp, input int hdr, input int plen);
    ssel = 1'b0;
    repeat (4) tick();
    if (hp) begin
      send_byte(8'(hdr));
      for (int i = 0; i < plen; i++) send_byte(pay[i]);
    end
    repeat (2) tick();
    ssel = 1'b1;
    repeat (8) tick();
  endtask

  task automatic pulse_rst(input logic [3:0] bits);
    ws_rst = bits;
    model_swap(bits);
    repeat (3) tick();
    ws_rst = 4'b0;
    repeat (2) tick();
  endtask

  task automatic check_all(input string tag);
    logic [3:0] eb;
    chk({tag, "_nwr_a"}, 64'(got0.size()), 64'(exp0.size()));
    for (int i = 0; i < exp0.size() && i < got0.size(); i++)
      chk($sformatf("%s_wr_a%0d", tag, i), got0[i], exp0[i]);
    chk({tag, "_nwr_b"}, 64'(got1.size()), 64'(exp1.size()));
    for (int i = 0; i < exp1.size() && i < got1.size(); i++)
      chk($sformatf("%s_wr_b%0d", tag, i), got1[i], exp1[i]);
    got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
    chk({tag, "_done_a"}, 64'(done_a), 64'(m_done[0]));
    chk({tag, "_done_b"}, 64'(done_b), 64'(m_done[1]));
    chk({tag, "_err_a"}, 64'(frame_err_a), 64'(m_err[0]));
    chk({tag, "_err_b"}, 64'(frame_err_b), 64'(m_err[1]));
    for (int c = 0; c < 4; c++) eb[c] = m_disp[0][c][0];
    chk({tag, "_bank_a"}, 64'(ws_bank_a), 64'(eb));
    for (int c = 0; c < 4; c++) eb[c] = m_disp[1][c][0];
    chk({tag, "_bank_b"}, 64'(ws_bank_b), 64'(eb));
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("%s_cnt_a%0d", tag, c), 64'((ws_count_a >> (3*c)) & 12'h7), 64'(m_wsc[0][c]));
      chk($sformatf("%s_cnt_b%0d", tag, c), 64'((ws_count_b >> (4*c)) & 16'hF), 64'(m_wsc[1][c]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"},   64'({wr_en_a, wr_en_b}), 64'(0));
    chk({tag, "_wr_addr"}, 64'({wr_addr_a, wr_addr_b}), 64'(0));
    chk({tag, "_wr_data"}, 64'({wr_data_a, wr_data_b}), 64'(0));
    chk({tag, "_bank"},    64'({ws_bank_a, ws_bank_b}), 64'(0));
    chk({tag, "_count"},   64'({ws_count_a, ws_count_b}), 64'(0));
    chk({tag, "_done"},    64'({frame_done_a, frame_done_b}), 64'(0));
    chk({tag, "_err"},     64'({frame_err_a, frame_err_b}), 64'(0));
  endtask

  task automatic load_req34();
    for (int i = 0; i < 6; i++) pay[i] = 8'(8'h10 * (i + 1));
  endtask

  initial begin
    bit hp;
    int hdr, plen;
    RESET_N = 1'b0; ssel = 1'b1; spi_data = 8'h00; spi_ready = 1'b0; ws_rst = 4'b0;
    m_done[0] = 0; m_done[1] = 0;
    model_reset();
    repeat (3) tick();
    check_reset_outputs("por");
    RESET_N = 1'b1;
    repeat (4) tick();

    // Basic RGB frame to channel 1, then latch to display it
    load_req34();
    send_frame(1'b1, 1, 6);
    model_frame(1'b1, 1, 6);
    chk("req34_d0", (got0.size() > 0) ? 64'(got0[0][31:0]) : 64'hx, 64'h102030);
    chk("req34_d1", (got0.size() > 1) ? 64'(got0[1][31:0]) : 64'hx, 64'h405060);
    check_all("req34");
    pulse_rst(4'b0010);
    chk("req34_bank1", 64'(ws_bank_a[1]), 64'(1));
    chk("req34_cnt1", 64'(ws_count_a[5:3]), 64'(2));
    check_all("req34_swap");

    // RGBW: five bytes, trailing partial byte dropped, no error
    for (int i = 0; i < 5; i++) pay[i] = 8'($urandom);
    send_frame(1'b1, 0, 5);
    model_frame(1'b1, 0, 5);
    chk("req35_err_b", 64'(frame_err_b), 64'(0));
    check_all("req35");
    pulse_rst(4'b0001);
    chk("req35_cnt_b0", 64'(ws_count_b[3:0]), 64'(1));
    check_all("req35_swap");

    // Two frames to channel 2 before the latch; latest frame wins
    for (int i = 0; i < 9; i++) pay[i] = 8'($urandom);
    send_frame(1'b1, 2, 9);
    model_frame(1'b1, 2, 9);
    check_all("req38_f1");
    for (int i = 0; i < 6; i++) pay[i] = 8'($urandom);
    send_frame(1'b1, 2, 6);
    model_frame(1'b1, 2, 6);
    check_all("req38_f2");
    pulse_rst(4'b0100);
    chk("req38_bank2", 64'(ws_bank_a[2]), 64'(1));
    chk("req38_cnt2", 64'(ws_count_a[8:6]), 64'(2));
    check_all("req38_swap");

    // Commit while the latch indicator is already high on channel 3
    ws_rst = 4'b1000;
    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
    send_frame(1'b1, 3, 8);
    model_frame(1'b1, 3, 8);
    ws_rst = 4'b0;
    tick();
    check_all("req28");

    // Reset in the middle of DATA with ssel still low
    ssel = 1'b0;
    repeat (4) tick();
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    RESET_N = 1'b0;
    repeat (2) tick();
    model_reset();
    check_reset_outputs("req39_rst");
    RESET_N = 1'b1;
    repeat (6) tick();
    check_all("req39_nostart");
    ssel = 1'b1;
    repeat (6) tick();
    load_req34();
    send_frame(1'b1, 1, 6);
    model_frame(1'b1, 1, 6);
    check_all("req39_frame");
    pulse_rst(4'b0010);
    chk("req39_cnt1", 64'(ws_count_a[5:3]), 64'(2));
    check_all("req39_swap");

    // Too many LEDs for dut_a (4 LED limit)
    for (int i = 0; i < 15; i++) pay[i] = 8'($urandom);
    send_frame(1'b1, 0, 15);
    model_frame(1'b1, 0, 15);
    chk("req37_err_a", 64'(frame_err_a), 64'(1));
    check_all("req37");
    pulse_rst(4'b0001);
    chk("req37_cnt_a0", 64'(ws_count_a[2:0]), 64'(4));
    check_all("req37_swap");

    // Invalid channel header
    for (int i = 0; i < 3; i++) pay[i] = 8'($urandom);
    send_frame(1'b1, 7, 3);
    model_frame(1'b1, 7, 3);
    chk("req36_err_b", 64'(frame_err_b), 64'(1));
    check_all("req36");

    // Randomized frames
    for (int it = 0; it < 30; it++) begin
      ws_rst = ($urandom % 4 == 0) ? 4'($urandom) : 4'b0;
      model_swap(ws_rst);
      repeat (3) tick();
      hp   = ($urandom % 8) != 0;
      hdr  = ($urandom % 6 == 0) ? int'($urandom_range(4, 255)) : int'($urandom % 4);
      plen = hp ? int'($urandom % 37) : 0;
      for (int i = 0; i < plen; i++) pay[i] = 8'($urandom);
      send_frame(hp, hdr, plen);
      model_frame(hp, hdr, plen);
      ws_rst = 4'b0;
      tick();
      if ($urandom % 2 == 0) pulse_rst(4'($urandom));
      check_all($sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
